// File: rtl/pixel_compositor_pkg.sv
// Shared encodings for the pixel compositor: game states, pixel classes,
// flash sequencer states and the idle level of the sync lines.
package pixel_compositor_pkg;

  localparam logic [1:0] GS_INIT = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] GS_DEAD = 2'b10;

  localparam logic SYNC_IDLE = 1'b1;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    BG    = 2'd1,
    WHITE = 2'd2,
    GREY  = 2'd3
  } pix_class_t;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_FLASH = 2'd1,
    FL_HOLD  = 2'd2
  } flash_state_t;

endpackage

// File: rtl/pixel_compositor_if.sv
// Bundles the compositor's scan, layer, game and colour signals; the slave
// modport is the compositor side, the master modport the driver side.
interface pixel_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int RW         = 3,
  parameter int GW         = 3,
  parameter int BW         = 2
);
  logic                  pix_en;
  logic [9:0]            vga_x;
  logic [8:0]            vga_y;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  frame_tick;
  logic [NUM_LAYERS-1:0] layer_grey;
  logic [NUM_LAYERS-1:0] layer_white;
  logic [1:0]            game_state;
  logic                  night_toggle;
  logic                  hsync_out;
  logic                  vsync_out;
  logic [RW-1:0]         vga_red;
  logic [GW-1:0]         vga_green;
  logic [BW-1:0]         vga_blue;
  logic                  night_mode;
  logic                  flash_active;
  logic                  collide;

  modport slave (
    input  pix_en, vga_x, vga_y, hsync_in, vsync_in, frame_tick,
           layer_grey, layer_white, game_state, night_toggle,
    output hsync_out, vsync_out, vga_red, vga_green, vga_blue,
           night_mode, flash_active, collide
  );

  modport master (
    output pix_en, vga_x, vga_y, hsync_in, vsync_in, frame_tick,
           layer_grey, layer_white, game_state, night_toggle,
    input  hsync_out, vsync_out, vga_red, vga_green, vga_blue,
           night_mode, flash_active, collide
  );
endinterface

// File: rtl/compositor_flash_ctrl.sv
// Death-flash sequencer: starts on a PLAY->DEAD step, counts frames and
// produces the palette flip phase; runs every clk, independent of pix_en.
module compositor_flash_ctrl
  import pixel_compositor_pkg::*;
#(
  parameter int FLASH_FRAMES      = 30,
  parameter int FLASH_PERIOD_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame_tick,
  input  logic [1:0] i_game_state,
  output logic       o_flash_active,
  output logic       o_flash_phase
);

  localparam logic [7:0] FRAME_LIMIT = 8'(FLASH_FRAMES);

  flash_state_t r_state, w_next_state;
  logic [7:0]   r_cnt, w_next_cnt;
  logic [1:0]   r_prev_gs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= FL_IDLE;
      r_cnt     <= 8'd0;
      r_prev_gs <= GS_INIT;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_prev_gs <= i_game_state;
    end
  end

  // A tick landing on the entry cycle is swallowed because IDLE never counts.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      FL_IDLE: begin
        if (r_prev_gs == GS_PLAY && i_game_state == GS_DEAD) begin
          w_next_state = FL_FLASH;
          w_next_cnt   = 8'd0;
        end
      end
      FL_FLASH: begin
        if (i_game_state != GS_DEAD) begin
          w_next_state = FL_IDLE;
        end else if (i_frame_tick) begin
          w_next_cnt = r_cnt + 8'd1;
          if (r_cnt + 8'd1 == FRAME_LIMIT) begin
            w_next_state = FL_HOLD;
          end
        end
      end
      FL_HOLD: begin
        if (i_game_state != GS_DEAD) begin
          w_next_state = FL_IDLE;
        end
      end
      default: w_next_state = FL_IDLE;
    endcase
  end

  assign o_flash_active = (r_state == FL_FLASH);
  assign o_flash_phase  = (r_state == FL_FLASH) & r_cnt[FLASH_PERIOD_LOG2];

endmodule

// File: rtl/pixel_compositor.sv
// Priority layer merge, night/flash palette and 2-stage sync-aligned pipeline.
// Optional collision detector enabled by PIXEL_COMPOSITOR_COLLISION_EN.
module pixel_compositor
  import pixel_compositor_pkg::*;
#(
  parameter int NUM_LAYERS        = 4,
  parameter int RW                = 3,
  parameter int GW                = 3,
  parameter int BW                = 2,
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480,
  parameter int FLASH_FRAMES      = 30,
  parameter int FLASH_PERIOD_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  pixel_compositor_if.slave bus
);

  localparam logic [9:0] X_LIMIT = 10'(SCREEN_W);
  localparam logic [8:0] Y_LIMIT = 9'(SCREEN_H);

  logic          w_visible;
  pix_class_t    w_class, r_class;
  logic          r_hs1, r_vs1, r_hs2, r_vs2;
  logic [RW-1:0] r_red;
  logic [GW-1:0] r_green;
  logic [BW-1:0] r_blue;
  logic          r_night, r_pending;
  logic          w_flash_active, w_flash_phase, w_invert, w_lit;

  assign w_visible = (bus.vga_x < X_LIMIT) && (bus.vga_y < Y_LIMIT);

  // Walk from the lowest priority layer up so layer 0 overwrites last.
  always_comb begin
    w_class = w_visible ? BG : BLANK;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_grey[i]) begin
        w_class = GREY;
      end else if (bus.layer_white[i]) begin
        w_class = WHITE;
      end
    end
  end

  assign w_invert = r_night ^ w_flash_phase;

  always_comb begin
    w_lit = 1'b0;
    case (r_class)
      GREY:      w_lit = w_invert;
      WHITE, BG: w_lit = ~w_invert;
      default:   w_lit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_class <= BLANK;
      r_hs1   <= SYNC_IDLE;
      r_vs1   <= SYNC_IDLE;
      r_hs2   <= SYNC_IDLE;
      r_vs2   <= SYNC_IDLE;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (bus.pix_en) begin
      r_class <= w_class;
      r_hs1   <= bus.hsync_in;
      r_vs1   <= bus.vsync_in;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      r_red   <= {RW{w_lit}};
      r_green <= {GW{w_lit}};
      r_blue  <= {BW{w_lit}};
    end
  end

  // Requests only take effect at a frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_night   <= 1'b0;
      r_pending <= 1'b0;
    end else if (bus.frame_tick) begin
      r_night   <= r_night ^ r_pending ^ bus.night_toggle;
      r_pending <= 1'b0;
    end else if (bus.night_toggle) begin
      r_pending <= ~r_pending;
    end
  end

  compositor_flash_ctrl #(
    .FLASH_FRAMES      (FLASH_FRAMES),
    .FLASH_PERIOD_LOG2 (FLASH_PERIOD_LOG2)
  ) u_flash (
    .clk            (clk),
    .rst            (rst),
    .i_frame_tick   (bus.frame_tick),
    .i_game_state   (bus.game_state),
    .o_flash_active (w_flash_active),
    .o_flash_phase  (w_flash_phase)
  );

`ifdef PIXEL_COMPOSITOR_COLLISION_EN
  logic w_hit, r_sticky, r_collide;

  assign w_hit = bus.pix_en & bus.layer_grey[0] & bus.layer_grey[1] & w_visible;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sticky  <= 1'b0;
      r_collide <= 1'b0;
    end else if (bus.frame_tick) begin
      r_collide <= r_sticky;
      r_sticky  <= w_hit;
    end else begin
      r_collide <= 1'b0;
      r_sticky  <= r_sticky | w_hit;
    end
  end

  assign bus.collide = r_collide;
`else
  assign bus.collide = 1'b0;
`endif

  assign bus.hsync_out    = r_hs2;
  assign bus.vsync_out    = r_vs2;
  assign bus.vga_red      = r_red;
  assign bus.vga_green    = r_green;
  assign bus.vga_blue     = r_blue;
  assign bus.night_mode   = r_night;
  assign bus.flash_active = w_flash_active;

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench: the stimulus side runs a frame-level reference model and
// queues expectations; the monitor pops and compares after every clock edge.
module tb_pixel_compositor;
  import pixel_compositor_pkg::*;

  localparam int NL = 4;
  localparam int RW = 3;
  localparam int GW = 3;
  localparam int BW = 2;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int FF = 30;
  localparam int FP = 2;

  localparam int K_BLANK = 0;
  localparam int K_LIGHT = 1;
  localparam int K_DARK  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pixel_compositor_if #(.NUM_LAYERS(NL), .RW(RW), .GW(GW), .BW(BW)) bus();

  pixel_compositor #(
    .NUM_LAYERS(NL), .RW(RW), .GW(GW), .BW(BW), .SCREEN_W(SW), .SCREEN_H(SH),
    .FLASH_FRAMES(FF), .FLASH_PERIOD_LOG2(FP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } pix_exp_t;

  typedef struct packed {
    logic night;
    logic flash;
    logic coll;
  } st_exp_t;

  pix_exp_t pixQ[$];
  st_exp_t  stQ[$];
  int       vectors = 0;
  int       miscompares = 0;
  bit       monOn = 1'b0;
  bit       sEn, sLive;

  // reference model state
  int         mNight, mPending, mInFlash, mHold, mTicks, mSticky;
  logic [1:0] mPrevGs;
  int         pendKind;
  logic       pendHs, pendVs;
  logic [1:0] curGs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input int x, input int y, input logic [NL-1:0] g,
                                  input logic [NL-1:0] w);
    for (int i = 0; i < NL; i++) begin
      if (g[i]) return K_DARK;
      if (w[i]) return K_LIGHT;
    end
    return (x < SW && y < SH) ? K_LIGHT : K_BLANK;
  endfunction

  function automatic int flashPhase();
    if (mInFlash == 0) return 0;
    return (mTicks / (1 << FP)) % 2;
  endfunction

  task automatic modelReset();
    mNight = 0; mPending = 0; mInFlash = 0; mHold = 0; mTicks = 0; mSticky = 0;
    mPrevGs = GS_INIT;
    pendKind = K_BLANK; pendHs = 1'b1; pendVs = 1'b1;
    pixQ.delete();
    stQ.delete();
  endtask

  // Drive one clock's worth of inputs, predict the edge, then wait for negedge.
  task automatic applyStimulus(input bit en, input int x, input int y,
                               input logic [NL-1:0] g, input logic [NL-1:0] w,
                               input logic [1:0] gs, input bit tog, input bit tick);
    logic hs, vs;
    int inv, coll, hit;
    pix_exp_t p;
    st_exp_t s;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    bus.pix_en = en; bus.vga_x = 10'(x); bus.vga_y = 9'(y);
    bus.hsync_in = hs; bus.vsync_in = vs;
    bus.layer_grey = g; bus.layer_white = w; bus.game_state = gs;
    bus.night_toggle = tog; bus.frame_tick = tick;

    if (en) begin
      inv = mNight ^ flashPhase();
      if (pendKind == K_BLANK) p.rgb = 8'h00;
      else p.rgb = (((pendKind == K_DARK) ? 1 : 0) ^ inv) != 0 ? 8'h00 : 8'hFF;
      p.hs = pendHs; p.vs = pendVs;
      pixQ.push_back(p);
      pendKind = classify(x, y, g, w); pendHs = hs; pendVs = vs;
    end

    if (tog) mPending ^= 1;
    if (tick) begin mNight ^= mPending; mPending = 0; end

    if ((mInFlash != 0 || mHold != 0) && gs != GS_DEAD) begin
      mInFlash = 0; mHold = 0;
    end else if (mInFlash != 0 && tick) begin
      mTicks++;
      if (mTicks == FF) begin mInFlash = 0; mHold = 1; end
    end else if (mInFlash == 0 && mHold == 0 && mPrevGs == GS_PLAY && gs == GS_DEAD) begin
      mInFlash = 1; mTicks = 0;
    end
    mPrevGs = gs;

`ifdef PIXEL_COMPOSITOR_COLLISION_EN
    hit = (en && g[0] && g[1] && x < SW && y < SH) ? 1 : 0;
    coll = tick ? mSticky : 0;
    if (tick) mSticky = 0;
    if (hit != 0) mSticky = 1;
`else
    hit = 0;
    coll = 0;
`endif
    s.night = (mNight != 0); s.flash = (mInFlash != 0); s.coll = (coll != 0);
    stQ.push_back(s);
    @(negedge clk);
  endtask

  task automatic checkOutput(input bit en);
    st_exp_t s;
    pix_exp_t p;
    if (stQ.size() == 0) begin
      check("state_queue_empty", 32'd1, 32'd0);
    end else begin
      s = stQ.pop_front();
      check("night_mode", 32'(bus.night_mode), 32'(s.night));
      check("flash_active", 32'(bus.flash_active), 32'(s.flash));
      check("collide", 32'(bus.collide), 32'(s.coll));
    end
    if (en) begin
      if (pixQ.size() == 0) begin
        check("pixel_queue_empty", 32'd1, 32'd0);
      end else begin
        p = pixQ.pop_front();
        check("pixel_rgb_hs_vs", 32'({bus.vga_red, bus.vga_green, bus.vga_blue,
                                      bus.hsync_out, bus.vsync_out}), 32'(p));
      end
    end
  endtask

  always @(posedge clk) begin
    sEn = bus.pix_en;
    sLive = monOn;
    #1;
    if (sLive) checkOutput(sEn);
  end

  task automatic frame(input int len, input int togA, input int togB,
                       input logic [NL-1:0] g, input int x, input int y);
    for (int c = 0; c < len; c++) begin
      applyStimulus(1'b1, x, y, g, '0, curGs, (c == togA) || (c == togB), c == len - 1);
    end
  endtask

  task automatic randomRun(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: curGs = GS_INIT;
          1: curGs = GS_PLAY;
          default: curGs = GS_DEAD;
        endcase
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 799), $urandom_range(0, 511),
                    NL'($urandom), NL'($urandom), curGs,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    bus.pix_en = 1'b1; bus.vga_x = 10'd100; bus.vga_y = 9'd100;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.frame_tick = 1'b1;
    bus.layer_grey = '1; bus.layer_white = '1; bus.game_state = GS_INIT;
    bus.night_toggle = 1'b1;
    curGs = GS_INIT;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rgb", 32'({bus.vga_red, bus.vga_green, bus.vga_blue}), 32'd0);
    check("reset_hsync", 32'(bus.hsync_out), 32'd1);
    check("reset_vsync", 32'(bus.vsync_out), 32'd1);
    check("reset_night", 32'(bus.night_mode), 32'd0);
    check("reset_flash", 32'(bus.flash_active), 32'd0);
    check("reset_collide", 32'(bus.collide), 32'd0);

    rst = 1'b1;
    modelReset();
    monOn = 1'b1;

    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 100, 100, 4'b0001, 4'b0010, curGs, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 100, 100, '0, '0, curGs, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 640, 100, '0, '0, curGs, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 100, 480, '0, '0, curGs, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, 639, 479, '0, '0, curGs, 1'b0, 1'b0);

    randomRun(300);

    curGs = GS_INIT;
    frame(10, 3, -1, 4'b0001, 100, 100);
    frame(10, 2, 5, 4'b0001, 100, 100);
    frame(10, 9, -1, 4'b0001, 100, 100);
    frame(10, -1, -1, 4'b0001, 100, 100);

    curGs = GS_PLAY;
    frame(6, -1, -1, '0, 100, 100);
    curGs = GS_DEAD;
    for (int f = 0; f < 34; f++) frame(6, -1, -1, '0, 100, 100);
    curGs = GS_INIT;
    frame(6, -1, -1, '0, 100, 100);
    curGs = GS_PLAY;
    frame(6, -1, -1, '0, 100, 100);
    curGs = GS_DEAD;
    frame(1, -1, -1, '0, 100, 100);
    for (int f = 0; f < 10; f++) frame(6, -1, -1, '0, 100, 100);
    curGs = GS_INIT;
    frame(6, -1, -1, '0, 100, 100);
    curGs = GS_DEAD;
    for (int f = 0; f < 10; f++) frame(6, -1, -1, '0, 100, 100);
    curGs = GS_INIT;
    frame(6, -1, -1, '0, 100, 100);

    applyStimulus(1'b1, 100, 100, 4'b0011, '0, curGs, 1'b0, 1'b0);
    frame(6, -1, -1, '0, 100, 100);
    frame(6, -1, -1, '0, 100, 100);
    applyStimulus(1'b1, 700, 100, 4'b0011, '0, curGs, 1'b0, 1'b0);
    frame(6, -1, -1, '0, 100, 100);
    frame(6, -1, -1, '0, 100, 100);

    randomRun(300);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 100, 100, '0, '0, curGs, 1'b0, 1'b0);

    monOn = 1'b0;
    @(negedge clk);
    check("queues_drained", 32'(pixQ.size() + stQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Parametrised successor to the fixed grey/white colour select at the end of the game top.
- Merges NUM_LAYERS sprite layers (dino, obstacles, ground, score, …) by priority. Adds a visible-area background and a two-stage registered pipeline with sync realignment.
- Adds a frame-synchronous night (inverted palette) mode and a death-flash sequencer driven by the game FSM state.
- Sits between the sprite delegates/VGA timing and the board's vgaRed/vgaGreen/vgaBlue pins.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; index 0 has highest priority.
- RW, 3, red channel width.
- GW, 3, green channel width.
- BW, 2, blue channel width.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in lines.
- FLASH_FRAMES, 30, frames of death flash (1..255).
- FLASH_PERIOD_LOG2, 2, flash toggles every 2^N frames.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- pix_en  in  1  pixel-clock enable strobe, 1 cycle per pixel
- vga_x  in  10  current scan X
- vga_y  in  9  current scan Y
- hsync_in  in  1  raw Hsync from VGA timing
- vsync_in  in  1  raw Vsync from VGA timing
- frame_tick  in  1  one-cycle pulse per frame
- layer_grey  in  NUM_LAYERS  per-layer "draw foreground" flags
- layer_white  in  NUM_LAYERS  per-layer "draw knockout" flags
- game_state  in  2  00 init, 01 play, 10 dead
- night_toggle  in  1  one-cycle request to invert palette
- hsync_out  out  1  Hsync delayed to match colour
- vsync_out  out  1  Vsync delayed to match colour
- vga_red  out  RW  red
- vga_green  out  GW  green
- vga_blue  out  BW  blue
- night_mode  out  1  current palette state
- flash_active  out  1  high during death flash
- collide  out  1  see Optional Feature

Behaviour:
- Reset (rst==0 at clk edge): colours 0, hsync_out=vsync_out=1, night_mode=0, flash FSM IDLE, flash_active=0, collide=0, pending toggle cleared.
- Pipeline advances only on pix_en. Total latency is 2 pix_en strobes; syncs pass through the same 2-stage delay.
- Stage 1, class select:
  - Scan layers from index 0 upward; the first layer with grey|white decides.
  - Within that layer, grey beats white.
  - No layer hit: BG if 0<=x<SCREEN_W and 0<=y<SCREEN_H, else BLANK.
- Stage 2, palette. invert = night_mode XOR flash_phase.
  - Normal: GREY→all-zero; WHITE and BG→all-ones.
  - Inverted: GREY→all-ones; WHITE and BG→all-zero.
  - BLANK is always all-zero regardless of invert.
- Night mode:
  - night_toggle XORs a pending bit.
  - On frame_tick, night_mode ^= pending, then pending clears.
  - Toggle coincident with frame_tick is applied on that tick.
  - Two toggles inside one frame cancel.
- Flash FSM (evaluated every clk, not gated by pix_en):
  - IDLE→FLASH when game_state goes 01→10 on consecutive clk cycles; frame_cnt=0.
  - FLASH: frame_cnt++ on each frame_tick. A tick coincident with entry is not counted.
  - flash_phase = frame_cnt[FLASH_PERIOD_LOG2].
  - FLASH→HOLD when frame_cnt reaches FLASH_FRAMES.
  - FLASH or HOLD→IDLE when game_state != 10; immediate exit is allowed mid-flash.
  - flash_active=1 only in FLASH; flash_phase=0 outside FLASH.
- Any other game_state transition, e.g. 00→10, does not start a flash.

Optional Feature:
- Macro: PIXEL_COMPOSITOR_COLLISION_EN.
- Enabled:
  - Sticky bit sets when layer_grey[0] & layer_grey[1] on a pix_en cycle inside the visible area.
  - On frame_tick, collide pulses 1 cycle with the sticky value; sticky clears.
- Disabled: collide tied 0; no collision logic synthesised.

Decomposition:
- Package pixel_compositor_pkg holds:
  - game state encodings GS_INIT/GS_PLAY/GS_DEAD;
  - pixel class enum BLANK/BG/WHITE/GREY (2 bits);
  - sync idle level constant.
- One sub-module: compositor_flash_ctrl. It contains the IDLE/FLASH/HOLD FSM, frame_cnt and flash_phase.
- Priority select and palette stay in pixel_compositor.

Test Plan:
- Reset, then layer_grey=0001 and layer_white=0010 at (100,100) with pix_en each cycle → after 2 strobes, colour=000/000/00; hsync_out equals hsync_in delayed 2 strobes.
- No layers hit: (100,100) → 111/111/11. (640,100) and (100,480) → 000/000/00.
- night_toggle mid-frame → palette unchanged until next frame_tick; then grey pixel→111/111/11 and night_mode=1. Two toggles in one frame → night_mode unchanged.
- game_state 01→10 with FLASH_FRAMES=30 and FLASH_PERIOD_LOG2=2 → flash_active high for exactly 30 frame_ticks; BG pixel colour inverts on frames 4–7, 12–15, 20–23, 28–29.
- game_state returns to 00 at frame 10 of the flash → flash_active=0 next cycle, normal palette. Entry 00→10 → no flash.
- With PIXEL_COMPOSITOR_COLLISION_EN: overlap of grey layers 0 and 1 on one visible pixel → collide=1 for one cycle at the next frame_tick, then 0 at the following tick. Overlap at x=700 → no pulse.
